// File: rtl/controle_pkg.sv
// Shared types and helpers for the multichannel lighting/load controller.
package controle_pkg;

    typedef enum logic [2:0] {
        LDA   = 3'd0,
        LLA   = 3'd1,
        LHOLD = 3'd2,
        LDM   = 3'd3,
        LMON  = 3'd4
    } state_t;

    function automatic int timer_width(input int hold);
        int w;
        w = $clog2(hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/controle_canal.sv
// One controller channel: button edge detect, auto/manual FSM, hold-off timer, output decode.
// Optional CONTROLE_ALL_OFF_EN adds a synchronous all_off override input.
module controle_canal
    import controle_pkg::*;
#(
    parameter int HOLD_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic mode_btn,
    input  logic man_btn,
    input  logic auto_off,
    input  logic auto_on,
`ifdef CONTROLE_ALL_OFF_EN
    input  logic all_off,
`endif
    output logic enable,
    output logic led,
    output logic saida
);

    localparam int TW = timer_width(HOLD_CYC);
    localparam logic [TW-1:0] LOAD = (HOLD_CYC > 0) ? TW'(HOLD_CYC - 1) : '0;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            mode_q, man_q;
    logic            mode_rise, man_rise;

    assign mode_rise = mode_btn & ~mode_q;
    assign man_rise  = man_btn & ~man_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LDA;
            timer  <= '0;
            mode_q <= 1'b0;
            man_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            timer  <= timer_nx;
            mode_q <= mode_btn;
            man_q  <= man_btn;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        case (state)
            LDA: begin
                if (mode_rise)    state_nx = LDM;
                else if (auto_on) state_nx = LLA;
            end
            LLA: begin
                if (mode_rise) begin
                    state_nx = LDM;
                end else if (auto_off && !auto_on) begin
                    if (HOLD_CYC == 0) begin
                        state_nx = LDA;
                    end else begin
                        state_nx = LHOLD;
                        timer_nx = LOAD;
                    end
                end
            end
            LHOLD: begin
                if (mode_rise) begin
                    state_nx = LDM;
                end else if (auto_on) begin
                    state_nx = LLA;
                    timer_nx = '0;
                end else if (timer == '0) begin
                    state_nx = LDA;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            LDM: begin
                if (mode_rise)     state_nx = auto_on ? LLA : LDA;
                else if (man_rise) state_nx = LMON;
            end
            LMON: begin
                if (mode_rise)     state_nx = auto_on ? LLA : LDA;
                else if (man_rise) state_nx = LDM;
            end
            default: begin
                state_nx = LDA;
                timer_nx = '0;
            end
        endcase
`ifdef CONTROLE_ALL_OFF_EN
        // Edge registers keep sampling, so held buttons do not fire on release.
        if (all_off) begin
            state_nx = LDA;
            timer_nx = '0;
        end
`endif
    end

    always_comb begin
        enable = 1'b0;
        led    = 1'b0;
        saida  = 1'b0;
        case (state)
            LLA, LHOLD: begin
                enable = 1'b1;
                saida  = 1'b1;
            end
            LDM: led = 1'b1;
            LMON: begin
                led   = 1'b1;
                saida = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/controle_multicanal.sv
// N-channel controller top: channel instances plus a registered count of active outputs.
// Optional CONTROLE_ALL_OFF_EN adds the all_off input broadcast to every channel.
module controle_multicanal
    import controle_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int HOLD_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            mode_btn,
    input  logic [N_CH-1:0]            man_btn,
    input  logic [N_CH-1:0]            auto_off,
    input  logic [N_CH-1:0]            auto_on,
`ifdef CONTROLE_ALL_OFF_EN
    input  logic                       all_off,
`endif
    output logic [N_CH-1:0]            enable,
    output logic [N_CH-1:0]            led,
    output logic [N_CH-1:0]            saida,
    output logic [$clog2(N_CH+1)-1:0]  on_count
);

    localparam int CW = $clog2(N_CH + 1);

    logic [CW-1:0] count_nx;

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        controle_canal #(
            .HOLD_CYC (HOLD_CYC)
        ) u_canal (
            .clk      (clk),
            .rst      (rst),
            .mode_btn (mode_btn[i]),
            .man_btn  (man_btn[i]),
            .auto_off (auto_off[i]),
            .auto_on  (auto_on[i]),
`ifdef CONTROLE_ALL_OFF_EN
            .all_off  (all_off),
`endif
            .enable   (enable[i]),
            .led      (led[i]),
            .saida    (saida[i])
        );
    end

    always_comb begin
        count_nx = '0;
        for (int i = 0; i < N_CH; i++) begin
            count_nx = count_nx + CW'(saida[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) on_count <= '0;
        else      on_count <= count_nx;
    end

endmodule

// File: tb/tb_controle_multicanal.sv
// Directed testbench for controle_multicanal with two channels and a four-cycle hold-off.
// Define CONTROLE_ALL_OFF_EN to also exercise the all_off override.
module tb_controle_multicanal;

    localparam int N_CH     = 2;
    localparam int HOLD_CYC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N_CH-1:0] mode_btn = '0;
    logic [N_CH-1:0] man_btn  = '0;
    logic [N_CH-1:0] auto_off = '0;
    logic [N_CH-1:0] auto_on  = '0;
`ifdef CONTROLE_ALL_OFF_EN
    logic            all_off  = 1'b0;
`endif
    logic [N_CH-1:0] enable, led, saida;
    logic [1:0]      on_count;

    int checks = 0;
    int errors = 0;

    controle_multicanal #(
        .N_CH     (N_CH),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_btn (mode_btn),
        .man_btn  (man_btn),
        .auto_off (auto_off),
        .auto_on  (auto_on),
`ifdef CONTROLE_ALL_OFF_EN
        .all_off  (all_off),
`endif
        .enable   (enable),
        .led      (led),
        .saida    (saida),
        .on_count (on_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({enable, led, saida, on_count} !== 8'h00) begin
            $display("FAIL reset_idle: got en=%b led=%b saida=%b cnt=%0d, want all 0", enable, led, saida, on_count);
            errors++;
        end
        auto_on = 2'b11;
        tick();
        tick();
        checks++;
        if (saida !== 2'b11 || on_count !== 2'd2) begin
            $display("FAIL reset_pre_lla: got saida=%b cnt=%0d, want 11 / 2", saida, on_count);
            errors++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({enable, led, saida, on_count} !== 8'h00) begin
            $display("FAIL reset_async: got en=%b led=%b saida=%b cnt=%0d, want all 0", enable, led, saida, on_count);
            errors++;
        end
        auto_on = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({enable, led, saida, on_count} !== 8'h00) begin
            $display("FAIL reset_release: got en=%b led=%b saida=%b cnt=%0d, want all 0", enable, led, saida, on_count);
            errors++;
        end
    endtask

    task automatic test_auto_hold();
        auto_on[0] = 1'b1;
        tick();
        checks++;
        if (saida !== 2'b01 || enable !== 2'b01 || on_count !== 2'd0) begin
            $display("FAIL hold_on: got saida=%b en=%b cnt=%0d, want 01/01/0", saida, enable, on_count);
            errors++;
        end
        auto_on[0]  = 1'b0;
        auto_off[0] = 1'b1;
        for (int k = 0; k < HOLD_CYC; k++) begin
            tick();
            checks++;
            if (saida !== 2'b01 || enable !== 2'b01 || led !== 2'b00 || on_count !== 2'd1) begin
                $display("FAIL hold_cycle%0d: got saida=%b en=%b led=%b cnt=%0d, want 01/01/00/1", k, saida, enable, led, on_count);
                errors++;
            end
        end
        tick();
        checks++;
        if (saida !== 2'b00 || on_count !== 2'd1) begin
            $display("FAIL hold_expire: got saida=%b cnt=%0d, want 00/1", saida, on_count);
            errors++;
        end
        tick();
        checks++;
        if (on_count !== 2'd0) begin
            $display("FAIL hold_count_lag: got cnt=%0d, want 0", on_count);
            errors++;
        end
        auto_off[0] = 1'b0;
    endtask

    task automatic test_hold_cancel();
        auto_on[0] = 1'b1;
        tick();
        auto_on[0]  = 1'b0;
        auto_off[0] = 1'b1;
        tick();
        tick();
        auto_on[0] = 1'b1;
        tick();
        checks++;
        if (saida[0] !== 1'b1 || enable[0] !== 1'b1) begin
            $display("FAIL cancel_back_lla: got saida=%b en=%b, want ch0 on", saida, enable);
            errors++;
        end
        auto_on[0] = 1'b0;
        for (int k = 0; k < HOLD_CYC; k++) begin
            tick();
            checks++;
            if (saida[0] !== 1'b1) begin
                $display("FAIL cancel_rehold%0d: got saida[0]=%b, want 1", k, saida[0]);
                errors++;
            end
        end
        tick();
        checks++;
        if (saida[0] !== 1'b0) begin
            $display("FAIL cancel_expire: got saida[0]=%b, want 0", saida[0]);
            errors++;
        end
        auto_off[0] = 1'b0;
        tick();
    endtask

    task automatic test_manual();
        mode_btn[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (led[1] !== 1'b1 || saida[1] !== 1'b0) begin
                $display("FAIL man_mode_held%0d: got led[1]=%b saida[1]=%b, want 1/0", k, led[1], saida[1]);
                errors++;
            end
        end
        mode_btn[1] = 1'b0;
        tick();
        man_btn[1] = 1'b1;
        tick();
        man_btn[1] = 1'b0;
        checks++;
        if (saida[1] !== 1'b1 || enable[1] !== 1'b0 || led[1] !== 1'b1) begin
            $display("FAIL man_llm: got saida=%b en=%b led=%b, want ch1 1/0/1", saida, enable, led);
            errors++;
        end
        tick();
        checks++;
        if (on_count !== 2'd1) begin
            $display("FAIL man_count: got cnt=%0d, want 1", on_count);
            errors++;
        end
        man_btn[1] = 1'b1;
        tick();
        man_btn[1] = 1'b0;
        checks++;
        if (saida[1] !== 1'b0 || led[1] !== 1'b1) begin
            $display("FAIL man_ldm: got saida[1]=%b led[1]=%b, want 0/1", saida[1], led[1]);
            errors++;
        end
        tick();
        mode_btn[1] = 1'b1;
        tick();
        mode_btn[1] = 1'b0;
        checks++;
        if ({enable[1], led[1], saida[1]} !== 3'b000) begin
            $display("FAIL man_exit: got en/led/saida=%b%b%b, want 000", enable[1], led[1], saida[1]);
            errors++;
        end
        tick();
    endtask

    task automatic test_priority();
        mode_btn[0] = 1'b1;
        tick();
        mode_btn[0] = 1'b0;
        tick();
        checks++;
        if (led[0] !== 1'b1) begin
            $display("FAIL prio_ldm1: got led[0]=%b, want 1", led[0]);
            errors++;
        end
        auto_on[0]  = 1'b1;
        mode_btn[0] = 1'b1;
        man_btn[0]  = 1'b1;
        tick();
        checks++;
        if (saida[0] !== 1'b1 || enable[0] !== 1'b1 || led[0] !== 1'b0) begin
            $display("FAIL prio_to_lla: got saida=%b en=%b led=%b, want ch0 1/1/0", saida, enable, led);
            errors++;
        end
        auto_on[0]  = 1'b0;
        mode_btn[0] = 1'b0;
        man_btn[0]  = 1'b0;
        tick();
        mode_btn[0] = 1'b1;
        tick();
        mode_btn[0] = 1'b0;
        tick();
        checks++;
        if (led[0] !== 1'b1 || saida[0] !== 1'b0) begin
            $display("FAIL prio_ldm2: got led[0]=%b saida[0]=%b, want 1/0", led[0], saida[0]);
            errors++;
        end
        mode_btn[0] = 1'b1;
        man_btn[0]  = 1'b1;
        tick();
        checks++;
        if ({enable[0], led[0], saida[0]} !== 3'b000) begin
            $display("FAIL prio_to_lda: got en/led/saida=%b%b%b, want 000", enable[0], led[0], saida[0]);
            errors++;
        end
        mode_btn[0] = 1'b0;
        man_btn[0]  = 1'b0;
        tick();
    endtask

`ifdef CONTROLE_ALL_OFF_EN
    task automatic test_all_off();
        auto_on[0] = 1'b1;
        mode_btn[1] = 1'b1;
        tick();
        mode_btn[1] = 1'b0;
        man_btn[1]  = 1'b1;
        tick();
        man_btn[1] = 1'b0;
        tick();
        checks++;
        if (saida !== 2'b11 || led !== 2'b10 || on_count !== 2'd2) begin
            $display("FAIL alloff_setup: got saida=%b led=%b cnt=%0d, want 11/10/2", saida, led, on_count);
            errors++;
        end
        all_off    = 1'b1;
        auto_on[0] = 1'b0;
        mode_btn   = 2'b11;
        man_btn[1] = 1'b1;
        tick();
        checks++;
        if ({enable, led, saida} !== 6'b0 || on_count !== 2'd2) begin
            $display("FAIL alloff_force: got en=%b led=%b saida=%b cnt=%0d, want 0/0/0/2", enable, led, saida, on_count);
            errors++;
        end
        tick();
        checks++;
        if (on_count !== 2'd0) begin
            $display("FAIL alloff_count: got cnt=%0d, want 0", on_count);
            errors++;
        end
        all_off = 1'b0;
        tick();
        checks++;
        if ({enable, led, saida} !== 6'b0) begin
            $display("FAIL alloff_release: got en=%b led=%b saida=%b, want all 0", enable, led, saida);
            errors++;
        end
        mode_btn = '0;
        man_btn  = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_auto_hold();
        test_hold_cancel();
        test_manual();
        test_priority();
`ifdef CONTROLE_ALL_OFF_EN
        test_all_off();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
